// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic datapath: FSM states, error codes and digit helpers.
package bcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIVIDE,
    ST_CONVERT,
    ST_DONE
  } state_e;

  localparam logic [7:0] ERR_DIVIDEND_DEF = 8'hF0;
  localparam logic [7:0] ERR_DIVISOR_DEF  = 8'h0F;
  localparam logic [7:0] ERR_BOTH_DEF     = 8'hFF;
  localparam logic [7:0] ERR_ZERO_DEF     = 8'hEE;

  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam int unsigned DIV_STEPS = 7;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bin7_to_bcd2.sv
// Combinational 7-bit binary (0..99) to two-digit BCD conversion.
module bin7_to_bcd2
  import bcd_pkg::*;
(
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  logic [3:0] tens;

  always_comb begin
    tens = '0;
    for (int unsigned i = 1; i <= BCD_MAX; i++) begin
      if (bin >= 7'(i * 10)) tens = 4'(i);
    end
    bcd = {tens, 4'(bin - {3'b000, tens} * 7'd10)};
  end

endmodule

// File: rtl/bcd_divider.sv
// Sequential 2-digit BCD by 1-digit BCD divider using a fixed 7-step restoring division.
module bcd_divider
  import bcd_pkg::*;
#(
  parameter logic [7:0] ERR_DIVIDEND = ERR_DIVIDEND_DEF,
  parameter logic [7:0] ERR_DIVISOR  = ERR_DIVISOR_DEF,
  parameter logic [7:0] ERR_BOTH     = ERR_BOTH_DEF,
  parameter logic [7:0] ERR_ZERO     = ERR_ZERO_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       ready,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       err
);

  state_e     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [6:0] work_q, work_d;
  logic [3:0] prem_q, prem_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       err_q, err_d;

  logic [4:0] shifted;
  logic       dvd_bad, dvs_bad;
  logic [7:0] quo_bcd;

  bin7_to_bcd2 u_conv (
    .bin (work_q),
    .bcd (quo_bcd)
  );

  // The partial remainder is always below the divisor, so 4 stored bits suffice;
  // the 5-bit shifted value carries the extra bit during the trial subtraction.
  assign shifted = {prem_q, work_q[6]};
  assign dvd_bad = !is_bcd(dvd_q[7:4]) || !is_bcd(dvd_q[3:0]);
  assign dvs_bad = !is_bcd(dvs_q);

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    work_d  = work_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (dvd_bad || dvs_bad || dvs_q == '0) begin
          if (dvd_bad && dvs_bad) quo_d = ERR_BOTH;
          else if (dvd_bad)       quo_d = ERR_DIVIDEND;
          else if (dvs_bad)       quo_d = ERR_DIVISOR;
          else                    quo_d = ERR_ZERO;
          rem_d   = 4'hF;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          work_d  = {3'b000, dvd_q[7:4]} * 7'd10 + {3'b000, dvd_q[3:0]};
          prem_d  = '0;
          cnt_d   = '0;
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (shifted >= {1'b0, dvs_q}) begin
          prem_d = 4'(shifted - {1'b0, dvs_q});
          work_d = {work_q[5:0], 1'b1};
        end else begin
          prem_d = shifted[3:0];
          work_d = {work_q[5:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(DIV_STEPS - 1)) state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        quo_d   = quo_bcd;
        rem_d   = prem_q;
        err_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      work_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      work_q  <= work_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_divider.sv
// Scoreboard bench for bcd_divider: directed vectors plus a full sweep of valid operands.
module tb_bcd_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       ready, done, err;
  logic [7:0] quotient;
  logic [3:0] remainder;

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        e;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  bcd_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic wait_ready();
    int unsigned guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within 100 cycles");
    end
  endtask

  // Drive one request and push its expected response; the monitor does the comparing.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] q, input logic [3:0] r, input logic e);
    exp_t x;
    wait_ready();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x.q = q; x.r = r; x.e = e;
    x.lat = e ? 1 : 9;
    x.acc = cyc;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("quotient", 32'(quotient), 32'(x.q));
        check("remainder", 32'(remainder), 32'(x.r));
        check("err", 32'(err), 32'(x.e));
        check("latency", cyc - x.acc, x.lat);
      end
    end
  end

  initial begin
    #3;
    check("rst_quotient", 32'(quotient), 32'h00);
    check("rst_remainder", 32'(remainder), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'h84, 4'h7, 8'h12, 4'h0, 1'b0);
    issue(8'h99, 4'h8, 8'h12, 4'h3, 1'b0);
    issue(8'h05, 4'h9, 8'h00, 4'h5, 1'b0);
    issue(8'h00, 4'h3, 8'h00, 4'h0, 1'b0);
    issue(8'h99, 4'h1, 8'h99, 4'h0, 1'b0);
    issue(8'h3A, 4'h4, 8'hF0, 4'hF, 1'b1);
    issue(8'h42, 4'hC, 8'h0F, 4'hF, 1'b1);
    issue(8'h3A, 4'hC, 8'hFF, 4'hF, 1'b1);
    issue(8'h42, 4'h0, 8'hEE, 4'hF, 1'b1);
    issue(8'hA0, 4'h0, 8'hF0, 4'hF, 1'b1);
    issue(8'h42, 4'hA, 8'h0F, 4'hF, 1'b1);

    // Busy-time start pulse and port changes must not disturb the running request.
    issue(8'h84, 4'h7, 8'h12, 4'h0, 1'b0);
    check("hold_quotient", 32'(quotient), 32'h0F);
    check("hold_err", 32'(err), 32'h1);
    repeat (2) @(negedge clk);
    dividend = 8'h55; divisor = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 8'h11; divisor = 4'h2;
    for (int i = 0; i < 20 && !done; i++) begin
      check("ready_busy", 32'(ready), 32'h0);
      @(negedge clk);
    end
    @(negedge clk);
    check("ready_after_done", 32'(ready), 32'h1);
    repeat (4) @(negedge clk);

    // Reset during DIVIDE aborts the request without a done.
    issue(8'h99, 4'h8, 8'h12, 4'h3, 1'b0);
    wait_ready();
    dividend = 8'h84; divisor = 4'h7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_quotient", 32'(quotient), 32'h00);
    check("abort_remainder", 32'(remainder), 32'h0);
    check("abort_err", 32'(err), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_ready", 32'(ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h63, 4'h9, 8'h07, 4'h0, 1'b0);

    for (int a = 0; a < 100; a++) begin
      for (int b = 0; b < 10; b++) begin
        if (b == 0)
          issue({4'(a / 10), 4'(a % 10)}, 4'(b), 8'hEE, 4'hF, 1'b1);
        else
          issue({4'(a / 10), 4'(a % 10)}, 4'(b),
                {4'((a / b) / 10), 4'((a / b) % 10)}, 4'(a % b), 1'b0);
      end
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
